// File: rtl/cmp_sort_pkg.sv
// Shared types and constants for the sequential comparator-based batch sorter.
package cmp_sort_pkg;

   typedef enum logic [1:0] {
      LOAD,
      SORT,
      DRAIN
   } state_t;

   localparam int CMP_GT = 2;
   localparam int CMP_EQ = 1;
   localparam int CMP_LT = 0;

   // Counters must be able to hold DEPTH itself (len), not just DEPTH-1.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/cmp_sort_seq_comparator.sv
// N-bit magnitude comparator; result is {A>B, A==B, A<B}.
module Comparator_Nbit #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [2:0]   result
);

   always_comb begin
      result = {(a > b), (a == b), (a < b)};
   end

endmodule

// File: rtl/cmp_sort_seq.sv
// Batch bubble sorter: loads up to DEPTH words, sorts with one shared comparator
// (one compare-and-swap per clock), then drains the sorted batch.
module cmp_sort_seq
   import cmp_sort_pkg::*;
#(
   parameter int N       = 4,
   parameter int DEPTH   = 8,
   parameter int DESCEND = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic         out_last,
   output logic         busy
);

   localparam int CW = cnt_width(DEPTH);
   localparam int AW = $clog2(DEPTH);

   state_t          state_q, state_d;
   logic [CW-1:0]   wr_q, wr_d, rd_q, rd_d, idx_q, idx_d, len_q, len_d;
   logic            swapped_q, swapped_d;
   logic [N-1:0]    buf_q [DEPTH];
   logic [N-1:0]    buf_d [DEPTH];

   logic [N-1:0]    cmp_a, cmp_b;
   logic [2:0]      cmp_r;
   logic            swap, accept, batch_end, pass_end;

   assign cmp_a = buf_q[AW'(idx_q)];
   assign cmp_b = buf_q[AW'(idx_q + CW'(1))];

   Comparator_Nbit #(.N(N)) u_cmp (
      .a      (cmp_a),
      .b      (cmp_b),
      .result (cmp_r)
   );

   // Equal words never swap, keeping the sort stable.
   assign swap      = (DESCEND != 0) ? cmp_r[CMP_LT] : cmp_r[CMP_GT];
   assign accept    = in_valid && in_ready;
   assign batch_end = in_last || (wr_q == CW'(DEPTH - 1));
   assign pass_end  = (idx_q == len_q - CW'(2));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= LOAD;
         wr_q      <= '0;
         rd_q      <= '0;
         idx_q     <= '0;
         len_q     <= '0;
         swapped_q <= 1'b0;
         buf_q     <= '{default: '0};
      end else begin
         state_q   <= state_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         idx_q     <= idx_d;
         len_q     <= len_d;
         swapped_q <= swapped_d;
         buf_q     <= buf_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      wr_d      = wr_q;
      rd_d      = rd_q;
      idx_d     = idx_q;
      len_d     = len_q;
      swapped_d = swapped_q;
      buf_d     = buf_q;
      case (state_q)
         LOAD: begin
            if (accept) begin
               buf_d[AW'(wr_q)] = in_data;
               wr_d             = wr_q + CW'(1);
               if (batch_end) begin
                  len_d     = wr_q + CW'(1);
                  idx_d     = '0;
                  swapped_d = 1'b0;
                  rd_d      = '0;
                  state_d   = (wr_q == '0) ? DRAIN : SORT;
               end
            end
         end
         SORT: begin
            if (swap) begin
               buf_d[AW'(idx_q)]            = cmp_b;
               buf_d[AW'(idx_q + CW'(1))]   = cmp_a;
               swapped_d                    = 1'b1;
            end
            // A swap on the last pair of a pass still forces another pass.
            if (pass_end) begin
               if (swapped_q || swap) begin
                  idx_d     = '0;
                  swapped_d = 1'b0;
               end else begin
                  state_d = DRAIN;
                  rd_d    = '0;
               end
            end else begin
               idx_d = idx_q + CW'(1);
            end
         end
         DRAIN: begin
            if (out_ready) begin
               rd_d = rd_q + CW'(1);
               if (out_last) begin
                  state_d = LOAD;
                  wr_d    = '0;
               end
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_comb begin
      in_ready  = rst_n && (state_q == LOAD);
      out_valid = (state_q == DRAIN);
      busy      = (state_q == SORT) || (state_q == DRAIN);
      out_data  = (state_q == DRAIN) ? buf_q[AW'(rd_q)] : '0;
      out_last  = (state_q == DRAIN) && (rd_q == len_q - CW'(1));
   end

   a_cmp_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot(cmp_r));

endmodule

// File: tb/tb_cmp_sort_seq.sv
// Directed self-checking bench for cmp_sort_seq (ascending and descending instances).
module tb_cmp_sort_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic [3:0] in_data = '0;
   logic       in_ready, out_valid, out_last, busy;
   logic [3:0] out_data;

   logic       in_valid_d = 1'b0, in_last_d = 1'b0, out_ready_d = 1'b0;
   logic [3:0] in_data_d = '0;
   logic       in_ready_d, out_valid_d, out_last_d, busy_d;
   logic [3:0] out_data_d;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cmp_sort_seq #(.N(4), .DEPTH(8), .DESCEND(0)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy)
   );

   cmp_sort_seq #(.N(4), .DEPTH(8), .DESCEND(1)) dut_desc (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_d), .in_ready(in_ready_d), .in_data(in_data_d), .in_last(in_last_d),
      .out_valid(out_valid_d), .out_ready(out_ready_d), .out_data(out_data_d), .out_last(out_last_d),
      .busy(busy_d)
   );

   // Stimulus helpers: all start and end on a negedge; they do not judge results
   // except for expired wait bounds.
   task automatic feed(input logic [3:0] w[8], input int n, input bit use_last);
      int t;
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = w[i];
         in_last  = use_last && (i == n - 1);
         t = 0;
         while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
         end
         if (!in_ready) begin
            checks++; errors++;
            $display("FAIL feed_timeout word %0d in_ready=%b required 1", i, in_ready);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   task automatic wait_sort(output int cyc);
      cyc = 0;
      while (busy && !out_valid && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      if (!out_valid) begin
         checks++; errors++;
         $display("FAIL sort_timeout out_valid=%b required 1", out_valid);
      end
   endtask

   task automatic drain(output logic [3:0] got[8], output bit lst[8], output int n);
      int t;
      n = 0;
      t = 0;
      got = '{default: '0};
      lst = '{default: 1'b0};
      out_ready = 1'b1;
      while (t < 100) begin
         if (out_valid) begin
            if (n < 8) begin
               got[n] = out_data;
               lst[n] = out_last;
            end
            n++;
            if (out_last) begin
               @(negedge clk);
               break;
            end
         end
         @(negedge clk);
         t++;
      end
      out_ready = 1'b0;
      if (t >= 100) begin
         checks++; errors++;
         $display("FAIL drain_timeout words=%0d required out_last", n);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (out_data !== 4'd0)  begin errors++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
      checks++; if (out_last !== 1'b0)  begin errors++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_full_no_last();
      logic [3:0] got[8];
      bit         lst[8];
      int         n, cyc;
      logic [3:0] exp[8];
      exp = '{1, 3, 6, 8, 9, 11, 14, 15};
      feed('{3, 14, 8, 11, 15, 6, 1, 9}, 8, 1'b0);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready_drop got=%b exp=0", in_ready); end
      checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL full_busy got=%b exp=1", busy); end
      wait_sort(cyc);
      drain(got, lst, n);
      checks++; if (n !== 8) begin errors++; $display("FAIL full_count got=%0d exp=8", n); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL full_data[%0d] got=%0d exp=%0d", i, got[i], exp[i]); end
         checks++; if (lst[i] !== (i == 7)) begin errors++; $display("FAIL full_last[%0d] got=%b exp=%b", i, lst[i], (i == 7)); end
      end
   endtask

   task automatic test_descend();
      logic [3:0] w[8];
      logic [3:0] exp[8];
      int         t, n;
      w   = '{3, 14, 8, 11, 15, 6, 1, 9};
      exp = '{15, 14, 11, 9, 8, 6, 3, 1};
      for (int i = 0; i < 8; i++) begin
         in_valid_d = 1'b1;
         in_data_d  = w[i];
         t = 0;
         while (!in_ready_d && t < 50) begin @(negedge clk); t++; end
         if (!in_ready_d) begin checks++; errors++; $display("FAIL desc_feed_timeout word %0d", i); end
         @(negedge clk);
      end
      in_valid_d = 1'b0;
      checks++; if (in_ready_d !== 1'b0) begin errors++; $display("FAIL desc_in_ready_drop got=%b exp=0", in_ready_d); end
      n = 0;
      t = 0;
      out_ready_d = 1'b1;
      while (t < 200 && n < 8) begin
         if (out_valid_d) begin
            checks++; if (out_data_d !== exp[n]) begin errors++; $display("FAIL desc_data[%0d] got=%0d exp=%0d", n, out_data_d, exp[n]); end
            checks++; if (out_last_d !== (n == 7)) begin errors++; $display("FAIL desc_last[%0d] got=%b exp=%b", n, out_last_d, (n == 7)); end
            n++;
         end
         @(negedge clk);
         t++;
      end
      out_ready_d = 1'b0;
      checks++; if (n !== 8) begin errors++; $display("FAIL desc_count got=%0d exp=8", n); end
      checks++; if (in_ready_d !== 1'b1) begin errors++; $display("FAIL desc_back_to_load got=%b exp=1", in_ready_d); end
   endtask

   task automatic test_presorted();
      logic [3:0] got[8];
      bit         lst[8];
      int         n, cyc;
      feed('{0, 1, 2, 3, 0, 0, 0, 0}, 4, 1'b1);
      wait_sort(cyc);
      checks++; if (cyc !== 3) begin errors++; $display("FAIL presorted_sort_cycles got=%0d exp=3", cyc); end
      drain(got, lst, n);
      checks++; if (n !== 4) begin errors++; $display("FAIL presorted_count got=%0d exp=4", n); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (got[i] !== 4'(i)) begin errors++; $display("FAIL presorted_data[%0d] got=%0d exp=%0d", i, got[i], i); end
         checks++; if (lst[i] !== (i == 3)) begin errors++; $display("FAIL presorted_last[%0d] got=%b exp=%b", i, lst[i], (i == 3)); end
      end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL presorted_in_ready_after got=%b exp=1", in_ready); end
   endtask

   task automatic test_single();
      logic [3:0] got[8];
      bit         lst[8];
      int         n;
      feed('{5, 0, 0, 0, 0, 0, 0, 0}, 1, 1'b1);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
      checks++; if (out_data !== 4'd5)  begin errors++; $display("FAIL single_out_data got=%0d exp=5", out_data); end
      checks++; if (out_last !== 1'b1)  begin errors++; $display("FAIL single_out_last got=%b exp=1", out_last); end
      drain(got, lst, n);
      checks++; if (n !== 1) begin errors++; $display("FAIL single_count got=%0d exp=1", n); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready_after got=%b exp=1", in_ready); end
   endtask

   task automatic test_reverse_and_dups();
      logic [3:0] got[8];
      bit         lst[8];
      int         n, cyc;
      logic [3:0] exp[8];
      feed('{15, 14, 13, 12, 11, 10, 9, 8}, 8, 1'b0);
      wait_sort(cyc);
      checks++; if (cyc !== 56) begin errors++; $display("FAIL reverse_sort_cycles got=%0d exp=56", cyc); end
      drain(got, lst, n);
      checks++; if (n !== 8) begin errors++; $display("FAIL reverse_count got=%0d exp=8", n); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (got[i] !== 4'(8 + i)) begin errors++; $display("FAIL reverse_data[%0d] got=%0d exp=%0d", i, got[i], 8 + i); end
      end
      exp = '{3, 3, 8, 8, 0, 0, 0, 0};
      feed('{8, 8, 3, 3, 0, 0, 0, 0}, 4, 1'b1);
      wait_sort(cyc);
      drain(got, lst, n);
      checks++; if (n !== 4) begin errors++; $display("FAIL dups_count got=%0d exp=4", n); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL dups_data[%0d] got=%0d exp=%0d", i, got[i], exp[i]); end
         checks++; if (lst[i] !== (i == 3)) begin errors++; $display("FAIL dups_last[%0d] got=%b exp=%b", i, lst[i], (i == 3)); end
      end
   endtask

   task automatic test_stall();
      logic [3:0] exp[8];
      logic [3:0] hd;
      logic       hl, held, done;
      int         n, cyc, c;
      exp = '{1, 2, 4, 7, 0, 0, 0, 0};
      feed('{4, 2, 7, 1, 0, 0, 0, 0}, 4, 1'b1);
      wait_sort(cyc);
      n = 0; c = 0; held = 1'b0; done = 1'b0; hd = '0; hl = 1'b0;
      while (!done && c < 100) begin
         out_ready = ((c % 4) == 0) || ((c % 4) == 3);
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc %0d got=%b exp=0", c, in_ready); end
         if (held) begin
            checks++; if (out_data !== hd) begin errors++; $display("FAIL stall_data_hold cyc %0d got=%0d exp=%0d", c, out_data, hd); end
            checks++; if (out_last !== hl) begin errors++; $display("FAIL stall_last_hold cyc %0d got=%b exp=%b", c, out_last, hl); end
         end
         if (out_valid && out_ready) begin
            if (n < 4) begin
               checks++; if (out_data !== exp[n]) begin errors++; $display("FAIL stall_data[%0d] got=%0d exp=%0d", n, out_data, exp[n]); end
               checks++; if (out_last !== (n == 3)) begin errors++; $display("FAIL stall_last[%0d] got=%b exp=%b", n, out_last, (n == 3)); end
            end
            n++;
            done = out_last;
         end
         held = out_valid && !out_ready;
         hd   = out_data;
         hl   = out_last;
         @(negedge clk);
         c++;
      end
      out_ready = 1'b0;
      checks++; if (n !== 4) begin errors++; $display("FAIL stall_count got=%0d exp=4", n); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_in_ready_after got=%b exp=1", in_ready); end
   endtask

   task automatic test_reset_midsort();
      logic [3:0] got[8];
      bit         lst[8];
      int         n, cyc;
      logic [3:0] exp[8];
      exp = '{2, 7, 9, 0, 0, 0, 0, 0};
      feed('{15, 14, 13, 12, 11, 10, 9, 8}, 8, 1'b0);
      repeat (10) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midsort_busy_before got=%b exp=1", busy); end
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midsort_rst_out_valid got=%b exp=0", out_valid); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL midsort_rst_busy got=%b exp=0", busy); end
      checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL midsort_rst_in_ready got=%b exp=0", in_ready); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midsort_release_in_ready got=%b exp=1", in_ready); end
      feed('{7, 2, 9, 0, 0, 0, 0, 0}, 3, 1'b1);
      wait_sort(cyc);
      drain(got, lst, n);
      checks++; if (n !== 3) begin errors++; $display("FAIL midsort_new_count got=%0d exp=3", n); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL midsort_new_data[%0d] got=%0d exp=%0d", i, got[i], exp[i]); end
         checks++; if (lst[i] !== (i == 2)) begin errors++; $display("FAIL midsort_new_last[%0d] got=%b exp=%b", i, lst[i], (i == 2)); end
      end
   endtask

   initial begin
      test_reset();
      test_full_no_last();
      test_descend();
      test_presorted();
      test_single();
      test_reverse_and_dups();
      test_stall();
      test_reset_midsort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
